// File: rtl/mvu_ram_pkg.sv
// Shared definitions for the MVU block-RAM read path: default geometry
// constants and the read-sequencer state encoding.
package mvu_ram_pkg;

  localparam int BDADDR_DEF = 12;    // RAM address width
  localparam int BDWORD_DEF = 2048;  // RAM word width (32 lanes x 64 bits)
  localparam int BDCNT_DEF  = 13;    // transfer length counter, up to 2**BDADDR words

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ram_stream_fifo2.sv
// Two-entry valid/ready FIFO. The head entry is presented combinationally;
// push and pop may happen in the same cycle in any state, including full.
// The caller only pops when out_valid is high and never pushes into a full
// FIFO without popping.
module ram_stream_fifo2 #(
  parameter int W = 2049
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   occupancy,
  output logic         out_valid,
  output logic [W-1:0] head_data
);

  logic [W-1:0] mem [0:1];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   cnt_reg;

  assign occupancy = cnt_reg;
  assign out_valid = (cnt_reg != 2'd0);
  assign head_data = mem[rd_ptr_reg];

  // Storage write; contents need no reset because cnt_reg gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      cnt_reg    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + 2'd1;
        2'b01:   cnt_reg <= cnt_reg - 2'd1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side sequencer for ram_simple2port: walks a strided address range,
// absorbs the one-cycle RAM read latency with a 2-entry buffer and hands
// the words downstream as a valid/ready stream with a last marker.
module ram_stream_reader
  import mvu_ram_pkg::*;
#(
  parameter int BDADDR = BDADDR_DEF,
  parameter int BDWORD = BDWORD_DEF,
  parameter int BDCNT  = BDCNT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BDADDR-1:0] base,
  input  logic [BDADDR-1:0] stride,
  input  logic [BDCNT-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              ram_rd_en,
  output logic [BDADDR-1:0] ram_rd_addr,
  input  logic [BDWORD-1:0] ram_rd_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BDWORD-1:0] out_word,
  output logic              out_last
);

  localparam logic [BDCNT-1:0] CNT_ONE = BDCNT'(1);

  state_t            state;
  logic [BDADDR-1:0] addr_reg;
  logic [BDADDR-1:0] stride_reg;
  logic [BDCNT-1:0]  count_reg;
  logic [BDCNT-1:0]  issued_reg;
  logic [BDCNT-1:0]  accepted_reg;
  logic              inflight_reg;
  logic              inflight_last_reg;

  logic [1:0]        occupancy;
  logic              fifo_valid;
  logic              head_last;
  logic [BDWORD-1:0] head_word;
  logic              pop;
  logic              credit_ok;
  logic              issue;
  logic              issue_last;

  // A read may only be issued if its word is guaranteed a buffer slot when it
  // returns next cycle: occupancy + inflight - pop_this_cycle < 2.
  assign pop        = fifo_valid & out_ready;
  assign credit_ok  = ({1'b0, occupancy} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop});
  assign issue      = (state == RUN) && (issued_reg < count_reg) && credit_ok;
  assign issue_last = issue && (issued_reg == count_reg - CNT_ONE);

  // The address register stops advancing on the final issue, so ram_rd_addr
  // keeps showing the last address read once the transfer is drained.
  assign ram_rd_en   = issue;
  assign ram_rd_addr = addr_reg;

  assign out_valid = fifo_valid;
  assign out_word  = head_word;
  assign out_last  = fifo_valid & head_last;

  ram_stream_fifo2 #(
    .W(BDWORD + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data ({inflight_last_reg, ram_rd_word}),
    .pop       (pop),
    .occupancy (occupancy),
    .out_valid (fifo_valid),
    .head_data ({head_last, head_word})
  );

  // Transfer sequencer: latches the request, counts issues and accepts, and
  // raises done in the cycle right after the final downstream handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      addr_reg          <= '0;
      stride_reg        <= '0;
      count_reg         <= '0;
      issued_reg        <= '0;
      accepted_reg      <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      done              <= 1'b0;
      inflight_reg      <= issue;
      inflight_last_reg <= issue_last;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              addr_reg     <= base;
              stride_reg   <= stride;
              count_reg    <= count;
              issued_reg   <= '0;
              accepted_reg <= '0;
              busy         <= 1'b1;
              state        <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            issued_reg <= issued_reg + CNT_ONE;
            if (issue_last) begin
              state <= DRAIN;
            end else begin
              addr_reg <= addr_reg + stride_reg;
            end
          end
          if (pop) begin
            accepted_reg <= accepted_reg + CNT_ONE;
          end
        end
        DRAIN: begin
          if (pop) begin
            accepted_reg <= accepted_reg + CNT_ONE;
            // Last accept empties the buffer; nothing is in flight by now.
            if (accepted_reg == count_reg - CNT_ONE) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: directed table of transfers,
// a mid-transfer reset sequence and a randomized scoreboard run against a
// behavioural RAM and stream model.
module tb_ram_stream_reader;

  logic          clk;
  logic          rst;
  logic          start;
  logic [11:0]   base;
  logic [11:0]   stride;
  logic [12:0]   count;
  logic          busy;
  logic          done;
  logic          ram_rd_en;
  logic [11:0]   ram_rd_addr;
  logic [2047:0] ram_rd_word;
  logic          out_valid;
  logic          out_ready;
  logic [2047:0] out_word;
  logic          out_last;

  int tests;
  int failed;
  int done_total;
  int last_total;
  int xfer_total;
  int nz_total;

  ram_stream_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base        (base),
    .stride      (stride),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_word (ram_rd_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_word    (out_word),
    .out_last    (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents are a fixed function of the address.
  function automatic logic [2047:0] ram_word(input logic [11:0] a);
    logic [2047:0] w;
    for (int i = 0; i < 64; i++) begin
      w[i*32 +: 32] = ({20'h0, a} * 32'h9E37_79B1) ^ (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
    end
    return w;
  endfunction

  // Behavioural RAM read port: one-cycle latency.
  always @(posedge clk) begin
    if (ram_rd_en) begin
      ram_rd_word <= ram_word(ram_rd_addr);
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_word(input string nm, input logic [2047:0] act, input logic [2047:0] exp);
    logic [63:0] a_lo;
    logic [63:0] e_lo;
    tests++;
    a_lo = act[63:0];
    e_lo = exp[63:0];
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got ..%h expected ..%h (t=%0t)", nm, a_lo, e_lo, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 3) == 0;
    return $urandom_range(0, 9) < 6;
  endfunction

  // Runs one transfer from start to a couple of idle cycles after completion,
  // checking every cycle against the expected stream.
  task automatic run_transfer(input logic [11:0] b, input logic [11:0] s, input logic [12:0] n,
                              input int mode, input bit glitch,
                              output int done_cyc, output logic [11:0] last_addr);
    int   iss, acc, last_hs, first_rd, first_val, done_cnt, budget, nn;
    logic hs, prev_stall, prev_last;
    logic [2047:0] prev_word;
    logic [11:0] a;
    nn = int'(n);
    done_cyc = -1; last_addr = '0;
    iss = 0; acc = 0; last_hs = -10; first_rd = -1; first_val = -1; done_cnt = 0;
    prev_stall = 1'b0; prev_last = 1'b0; prev_word = '0;
    budget = 8 * nn + 40;
    @(posedge clk); #1;
    start = 1'b1; base = b; stride = s; count = n; out_ready = ready_for(mode, 0);
    for (int k = 0; ; k++) begin
      @(negedge clk);
      hs = out_valid && out_ready;
      check("busy", 64'(busy), 64'((nn != 0) && (k >= 1) && (acc < nn)));
      check("done", 64'(done), 64'((nn == 0) ? (k == 1) : ((acc == nn) && (last_hs == k - 1))));
      if (done) begin
        done_cnt++;
        done_cyc = k;
      end
      if (ram_rd_en) begin
        if (first_rd < 0) first_rd = k;
        a = 12'(int'(b) + iss * int'(s));
        check("rd_within_count", 64'(iss < nn), 64'd1);
        check("rd_addr", 64'(ram_rd_addr), 64'(a));
        last_addr = ram_rd_addr;
        iss++;
      end
      check("outstanding", 64'((iss - acc - int'(hs)) <= 2), 64'd1);
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check_word("stall_word", out_word, prev_word);
        check("stall_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid) begin
        if (first_val < 0) first_val = k;
        check("valid_within_count", 64'(acc < nn), 64'd1);
      end
      if (hs) begin
        a = 12'(int'(b) + acc * int'(s));
        check_word("word", out_word, ram_word(a));
        check("last", 64'(out_last), 64'(acc == nn - 1));
        if (out_last) last_total++;
        acc++;
        last_hs = k;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = out_word;
      prev_last  = out_last;
      if ((nn == 0 && k >= 3) || (nn != 0 && acc == nn && k >= last_hs + 3)) break;
      if (k >= budget) begin
        tests++;
        failed++;
        $display("FAIL timeout: transfer base=%03h count=%0d stuck at %0d of %0d words", b, nn, acc, nn);
        break;
      end
      @(posedge clk); #1;
      if (glitch && (k + 1 == 2)) begin
        start = 1'b1; base = 12'hABC; stride = 12'h003; count = 13'd5;
      end else begin
        start = 1'b0; base = 12'($urandom); stride = 12'($urandom); count = 13'($urandom);
      end
      out_ready = ready_for(mode, k + 1);
    end
    check("done_count", 64'(done_cnt), 64'd1);
    check("issued", 64'(iss), 64'(nn));
    check("accepted", 64'(acc), 64'(nn));
    if (mode == 0 && nn != 0) begin
      check("first_rd_cycle", 64'(first_rd), 64'd1);
      check("first_valid_cycle", 64'(first_val), 64'd3);
    end
    done_total += done_cnt;
    xfer_total++;
    if (nn != 0) nz_total++;
    start = 1'b0;
    $display("[TB] xfer base=%03h stride=%03h count=%0d ready_mode=%0d done_cycle=%0d", b, s, nn, mode, done_cyc);
  endtask

  typedef struct {
    logic [11:0] base;
    logic [11:0] stride;
    logic [12:0] count;
    int          mode;
    bit          glitch;
    logic [11:0] exp_last_addr;
    int          exp_done_cycle;  // -1 when ready is not held high
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dc, hs_cnt;
    logic [11:0] la;
    logic [11:0] rb, rs;
    logic [12:0] rn;
    tests = 0; failed = 0; done_total = 0; last_total = 0; xfer_total = 0; nz_total = 0;
    rst = 1'b1; start = 1'b0; base = '0; stride = '0; count = '0; out_ready = 1'b0;

    vecs[0] = '{12'h010, 12'h001, 13'd8, 0, 1'b0, 12'h017, 11};
    vecs[1] = '{12'h100, 12'h004, 13'd6, 1, 1'b1, 12'h114, -1};
    vecs[2] = '{12'hFFE, 12'h001, 13'd4, 0, 1'b0, 12'h001, 7};
    vecs[3] = '{12'h3C3, 12'h001, 13'd0, 0, 1'b0, 12'h000, 1};
    vecs[4] = '{12'h5A5, 12'h007, 13'd1, 0, 1'b0, 12'h5A5, 4};
    vecs[5] = '{12'h055, 12'h000, 13'd3, 1, 1'b0, 12'h055, -1};
    vecs[6] = '{12'hF00, 12'h081, 13'd5, 2, 1'b0, 12'h104, -1};
    vecs[7] = '{12'h7FF, 12'h800, 13'd2, 0, 1'b1, 12'hFFF, 5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_en", 64'(ram_rd_en), 64'd0);
    check("rst_rd_addr", 64'(ram_rd_addr), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed transfers.
    for (int i = 0; i < 8; i++) begin
      run_transfer(vecs[i].base, vecs[i].stride, vecs[i].count, vecs[i].mode, vecs[i].glitch, dc, la);
      if (vecs[i].count != 0) check("vec_last_addr", 64'(la), 64'(vecs[i].exp_last_addr));
      if (vecs[i].exp_done_cycle >= 0) check("vec_done_cycle", 64'(dc), 64'(vecs[i].exp_done_cycle));
    end

    // Reset in the middle of a stalled transfer.
    @(posedge clk); #1;
    start = 1'b1; base = 12'h200; stride = 12'h001; count = 13'd16; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hs_cnt = 0;
    for (int k = 0; k < 40 && hs_cnt < 3; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) hs_cnt++;
    end
    check("abort_pre_handshakes", 64'(hs_cnt), 64'd3);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_pre_valid", 64'(out_valid), 64'd1);
    check("abort_pre_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_rd_en", 64'(ram_rd_en), 64'd0);
    check("abort_rd_addr", 64'(ram_rd_addr), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_last", 64'(out_last), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_quiet", 64'({done, out_valid, ram_rd_en, busy}), 64'd0);
    end
    run_transfer(12'h020, 12'h001, 13'd2, 0, 1'b0, dc, la);
    check("post_abort_done_cycle", 64'(dc), 64'd5);
    check("post_abort_last_addr", 64'(la), 64'h021);

    // Randomized scoreboard run.
    for (int t = 0; t < 200; t++) begin
      rb = 12'($urandom);
      rs = ($urandom_range(0, 4) == 0) ? 12'h000 : 12'($urandom);
      rn = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(0, 1)) : 13'($urandom_range(2, 24));
      run_transfer(rb, rs, rn, 2, (rn != 0) && ($urandom_range(0, 3) == 0), dc, la);
    end

    check("total_done_pulses", 64'(done_total), 64'(xfer_total));
    check("total_last_words", 64'(last_total), 64'(nz_total));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
